// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core LSU (port 0) and debug/DMA (port 1) share one
// single-cycle registered memory. Define DMEM_ARB_RR_EN for round-robin tie-breaking.
module dmem_arbiter #(
  parameter int NUM_WORDS = 32
) (
  input  logic        clk,
  input  logic        n_rst,

  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic        mem_wr,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(NUM_WORDS);

  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;
  logic        tie_to_port0;
  logic        sel_we;
  logic        sel_err;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  logic        rsp_valid_q;
  logic        rsp_port_q;
  logic        rsp_we_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data;

`ifdef DMEM_ARB_RR_EN
  // Port granted most recently; 1 out of reset so port 0 wins the first tie.
  logic last_gnt_q;

  assign tie_to_port0 = last_gnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_gnt_q <= 1'b1;
    end else if (any_gnt) begin
      last_gnt_q <= gnt1;
    end
  end
`else
  assign tie_to_port0 = 1'b1;
`endif

  // Grant is purely combinational so a lone requester is accepted every cycle.
  always_comb begin
    gnt0    = req0_valid && (!req1_valid || tie_to_port0);
    gnt1    = req1_valid && !gnt0;
    any_gnt = gnt0 || gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt1) begin
      sel_we    = req1_we;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end else if (gnt0) begin
      sel_we    = req0_we;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
    end
    sel_err = any_gnt && (sel_addr >= ADDR_LIMIT);
  end

  // Out-of-range accesses still occupy the grant slot but never strobe the memory.
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign mem_wr    = any_gnt && sel_we  && !sel_err;
  assign mem_rd    = any_gnt && !sel_we && !sel_err;

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= any_gnt;
      rsp_port_q  <= gnt1;
      rsp_we_q    <= sel_we;
      rsp_err_q   <= sel_err;
    end
  end

  // The memory registers its own read data, so load data is forwarded straight through.
  assign rsp_data = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? mem_rdata : 32'h0;

  assign rsp0_valid = rsp_valid_q && !rsp_port_q;
  assign rsp1_valid = rsp_valid_q &&  rsp_port_q;
  assign rsp0_rdata = rsp0_valid ? rsp_data : 32'h0;
  assign rsp1_rdata = rsp1_valid ? rsp_data : 32'h0;
  assign rsp0_err   = rsp0_valid && rsp_err_q;
  assign rsp1_err   = rsp1_valid && rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against
// a transaction-level model of arbitration, address checking and the attached memory.
module tb_dmem_arbiter;

  localparam int NUM_WORDS = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, rsp0_valid, rsp0_err;
  logic        req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_wr, mem_rd;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Attached memory: one-cycle registered read, preloaded with a known pattern in reset.
  logic [31:0] mem [NUM_WORDS];
  always @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= init_word(i);
      mem_rdata <= 32'h0;
    end else begin
      if (mem_wr && mem_addr < NUM_WORDS) mem[mem_addr] <= mem_wdata;
      if (mem_rd && mem_addr < NUM_WORDS) mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model: transaction-level view of the arbiter and memory.
  logic [31:0] ref_mem [NUM_WORDS];
  int          last_port;
  logic        exp_valid [2];
  logic        exp_err   [2];
  logic [31:0] exp_rdata [2];

  function automatic void model_reset();
    for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = init_word(i);
    last_port = 1;
    for (int p = 0; p < 2; p++) begin
      exp_valid[p] = 1'b0;
      exp_err[p]   = 1'b0;
      exp_rdata[p] = 32'h0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_rsp();
    check("rsp0_valid", 32'(rsp0_valid), 32'(exp_valid[0]));
    check("rsp0_err",   32'(rsp0_err),   32'(exp_err[0]));
    check("rsp0_rdata", rsp0_rdata,      exp_rdata[0]);
    check("rsp1_valid", 32'(rsp1_valid), 32'(exp_valid[1]));
    check("rsp1_err",   32'(rsp1_err),   32'(exp_err[1]));
    check("rsp1_rdata", rsp1_rdata,      exp_rdata[1]);
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance model, return grant (-1 = none).
  task automatic step(input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                      output int g);
    logic [31:0] ga, gd;
    bit          gwe, gerr;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    @(negedge clk);
    if (v0 && v1)  g = (RR && last_port == 0) ? 1 : 0;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    else           g = -1;
    ga   = (g == 1) ? a1 : (g == 0) ? a0 : 32'h0;
    gd   = (g == 1) ? d1 : (g == 0) ? d0 : 32'h0;
    gwe  = (g == 1) ? we1 : (g == 0) ? we0 : 1'b0;
    gerr = (g >= 0) && (ga >= NUM_WORDS);

    check("req0_ready", 32'(req0_ready), 32'(g == 0));
    check("req1_ready", 32'(req1_ready), 32'(g == 1));
    check("mem_wr",     32'(mem_wr),     32'(g >= 0 && gwe && !gerr));
    check("mem_rd",     32'(mem_rd),     32'(g >= 0 && !gwe && !gerr));
    check("mem_addr",   mem_addr,        ga);
    check("mem_wdata",  mem_wdata,       gd);
    check_rsp();

    for (int p = 0; p < 2; p++) begin
      exp_valid[p] = (g == p);
      exp_err[p]   = (g == p) && gerr;
      exp_rdata[p] = 32'h0;
    end
    if (g >= 0) begin
      if (!gwe && !gerr) exp_rdata[g] = ref_mem[ga];
      if (gwe && !gerr)  ref_mem[ga] = gd;
      last_port = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  int g;
  int grants [4];
  int exp_grants [4];
  logic [31:0] ra0, ra1;

  initial begin
`ifdef DMEM_ARB_RR_EN
    exp_grants = '{0, 1, 0, 1};
`else
    exp_grants = '{0, 0, 0, 0};
`endif
    model_reset();

    // Reset state with everything idle.
    #2;
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
    check("rst_mem_wr",     32'(mem_wr),     32'h0);
    check("rst_mem_rd",     32'(mem_rd),     32'h0);
    check("rst_ready1",     32'(req1_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // Both ports valid for four cycles straight out of reset.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'(i), 0, 1, 0, 32'(i + 8), 0, g);
      grants[i] = g;
    end
    for (int i = 0; i < 4; i++) check($sformatf("tie_grant%0d", i), 32'(grants[i]), 32'(exp_grants[i]));
    idle(2);

    // Lone debug-port load is granted immediately.
    step(0, 0, 0, 0, 1, 0, 32'd5, 0, g);
    check("lone_req1_grant", 32'(g), 32'd1);
    idle(1);

    // Store then load the same word on the LSU port.
    step(1, 1, 32'd3, 32'hDEADBEEF, 0, 0, 0, 0, g);
    check("st_rsp0_valid", 32'(rsp0_valid), 32'h1);
    step(1, 0, 32'd3, 0, 0, 0, 0, 0, g);
    check("ld_rsp0_valid", 32'(rsp0_valid), 32'h1);
    check("ld_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
    check("ld_rsp0_err",   32'(rsp0_err), 32'h0);
    idle(1);

    // Out-of-range load at the first invalid address.
    step(0, 0, 0, 0, 1, 0, 32'(NUM_WORDS), 0, g);
    check("oor_rsp1_err",   32'(rsp1_err),   32'h1);
    check("oor_rsp1_rdata", rsp1_rdata,      32'h0);
    idle(1);

    // Reset asserted while a load response is in flight.
    step(1, 0, 32'd7, 0, 0, 0, 0, 0, g);
    n_rst = 1'b0;
    req0_valid = 1'b0;
    #1;
    check("rst_mid_rsp0_valid", 32'(rsp0_valid), 32'h0);
    check("rst_mid_rsp0_rdata", rsp0_rdata,      32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    idle(3);

    // Random traffic; addresses mostly clustered so stores and loads collide.
    for (int i = 0; i < 400; i++) begin
      ra0 = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, NUM_WORDS + 3));
      ra1 = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NUM_WORDS + 3));
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra0, $urandom,
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra1, $urandom, g);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 32, meaning the number of 32-bit words in the attached data memory; valid word addresses are 0..NUM_WORDS-1.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port reqN_valid, input, 1 bit, for N=0,1: requester N presents an access. Port 0 is the core LSU; port 1 is the debug/DMA port.
REQ-005 SHALL have port reqN_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port reqN_addr, input, 32 bits: word address.
REQ-007 SHALL have port reqN_wdata, input, 32 bits: store data.
REQ-008 SHALL have port reqN_ready, output, 1 bit: grant; the access is accepted when valid and ready are both 1 in the same cycle.
REQ-009 SHALL have port rspN_valid, output, 1 bit: response strobe.
REQ-010 SHALL have port rspN_rdata, output, 32 bits: load data.
REQ-011 SHALL have port rspN_err, output, 1 bit: out-of-range address.
REQ-012 SHALL have port mem_wr, output, 1 bit: memory write strobe.
REQ-013 SHALL have port mem_rd, output, 1 bit: memory read strobe.
REQ-014 SHALL have port mem_addr, output, 32 bits: memory address.
REQ-015 SHALL have port mem_wdata, output, 32 bits: memory write data.
REQ-016 SHALL have port mem_rdata, input, 32 bits: memory output, registered by the memory, valid one cycle after the strobe.

Function
REQ-017 SHALL grant at most one requester per cycle; reqN_ready is combinational from the valid inputs and the arbitration state, and is 0 for a requester whose valid is 0.
REQ-018 SHALL drive the granted request onto mem_addr/mem_wdata in the grant cycle, with mem_wr=we and mem_rd=!we; with no grant, mem_wr=mem_rd=0 and mem_addr/mem_wdata=0.
REQ-019 SHALL suppress mem_wr and mem_rd for a granted request with addr >= NUM_WORDS.
REQ-020 SHALL register the granted port, we and error flag, and assert rspN_valid for exactly one cycle in the cycle after the grant (latency 1); throughput is one access per cycle.
REQ-021 SHALL drive rspN_rdata=mem_rdata for a load response, 0 for a store response, and 0 for an error response; rspN_err=1 only with an out-of-range rspN_valid.
REQ-022 SHALL hold rspN_rdata/rspN_err at 0 whenever rspN_valid=0.
REQ-023 SHALL provide store-to-response ordering: a load granted in cycle N+1 to the address stored in cycle N returns the stored data.
REQ-024 SHALL, with only one requester valid, grant that requester every cycle.

Reset
REQ-025 SHALL, while n_rst=0, force all response registers and rspN_valid to 0 and reset the last-grant pointer to port 1, so port 0 wins the first tie.
REQ-026 SHALL drop any in-flight response when reset asserts mid-access; no response is issued after reset release.

Configuration
REQ-027 SHALL use the macro DMEM_ARB_RR_EN: when defined, ties are resolved round-robin (the port not granted most recently wins and the pointer updates on every grant); when undefined, port 0 always wins ties and the pointer is unused.

Verification
REQ-028 SHALL be tested so that: req0 store addr=3 wdata=0xDEADBEEF, next cycle req0 load addr=3 -> rsp0_valid one cycle after each access; load rdata=0xDEADBEEF, err=0.
REQ-029 SHALL be tested so that: req1 load addr=32 with NUM_WORDS=32 -> mem_rd=0, and next cycle rsp1_valid=1, rsp1_err=1, rsp1_rdata=0.
REQ-030 SHALL be tested so that: both ports valid for 4 cycles with DMEM_ARB_RR_EN defined -> grants 0,1,0,1.
REQ-031 SHALL be tested so that: both ports valid for 4 cycles with DMEM_ARB_RR_EN undefined -> grants 0,0,0,0 and req1_ready=0 throughout.
REQ-032 SHALL be tested so that: a load is granted, then n_rst is asserted in the following cycle before the edge -> rsp0_valid=0, with no response after release.
REQ-033 SHALL be tested so that: req1 load addr=5 is issued with no other traffic -> req1_ready=1 in the same cycle, mem_rd=1, mem_addr=5.
